// File: rtl/rom_loader.sv
// Instruction ROM for the Hack computer, filled from a big-endian byte stream
// (count, words, optional checksum). Optional checksum: ROM_LOADER_CHECKSUM_EN.
module rom_loader #(
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic              load_req,
    input  logic [ADDR_W-1:0] pc,
    output logic [15:0]       instruction,
    output logic              cpu_reset,
    output logic              loading,
    output logic              error
);

    typedef enum logic [2:0] {
        HDR_HI, HDR_LO, DATA_HI, DATA_LO, RUN, ERR
`ifdef ROM_LOADER_CHECKSUM_EN
        , CHK_HI, CHK_LO
`endif
    } state_t;

`ifdef ROM_LOADER_CHECKSUM_EN
    localparam state_t AFTER_DATA = CHK_HI;
`else
    localparam state_t AFTER_DATA = RUN;
`endif

    // Largest legal word count; 17 bits so ADDR_W=16 still fits.
    localparam logic [16:0] DEPTH = 17'd1 << ADDR_W;

    state_t            state, next_state;
    logic [15:0]       count;
    logic [7:0]        hi_byte;
    logic [ADDR_W-1:0] waddr;
    logic              accept;
    logic              rom_we;
    logic [15:0]       rx_word;
    logic [15:0]       hdr_n;
    logic              last_word;
    logic              restart;
`ifdef ROM_LOADER_CHECKSUM_EN
    logic [15:0]       csum;
`endif

    logic [15:0] rom [0:(1 << ADDR_W) - 1];

    assign loading   = (state != RUN) && (state != ERR);
    assign error     = (state == ERR);
    assign rx_ready  = loading && !reset;
    assign accept    = rx_valid && rx_ready;
    assign rx_word   = {hi_byte, rx_data};
    assign hdr_n     = {count[15:8], rx_data};
    assign last_word = (17'(waddr) + 17'd1) == 17'(count);
    assign restart   = !loading && (next_state == HDR_HI);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= HDR_HI;
        else       state <= next_state;
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        next_state = state;
        rom_we     = 1'b0;
        case (state)
            HDR_HI:  if (accept) next_state = HDR_LO;
            HDR_LO: begin
                if (accept) begin
                    if (hdr_n == 16'd0)          next_state = AFTER_DATA;
                    else if (17'(hdr_n) > DEPTH) next_state = ERR;
                    else                         next_state = DATA_HI;
                end
            end
            DATA_HI: if (accept) next_state = DATA_LO;
            DATA_LO: begin
                if (accept) begin
                    rom_we     = 1'b1;
                    next_state = last_word ? AFTER_DATA : DATA_HI;
                end
            end
`ifdef ROM_LOADER_CHECKSUM_EN
            CHK_HI:  if (accept) next_state = CHK_LO;
            CHK_LO:  if (accept) next_state = (rx_word == csum) ? RUN : ERR;
`endif
            RUN:     if (load_req) next_state = HDR_HI;
            ERR:     if (load_req) next_state = HDR_HI;
            default: next_state = HDR_HI;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_reset <= 1'b1;
            count     <= '0;
            hi_byte   <= '0;
            waddr     <= '0;
`ifdef ROM_LOADER_CHECKSUM_EN
            csum      <= '0;
`endif
        end else begin
            // Registered from next_state so release and re-hold track the state edge.
            cpu_reset <= (next_state != RUN);
            if (restart) begin
                waddr <= '0;
`ifdef ROM_LOADER_CHECKSUM_EN
                csum  <= '0;
`endif
            end
            if (accept) begin
                case (state)
                    HDR_HI:  count[15:8] <= rx_data;
                    HDR_LO:  count[7:0]  <= rx_data;
                    DATA_HI: hi_byte     <= rx_data;
                    DATA_LO: begin
                        waddr <= waddr + ADDR_W'(1);
`ifdef ROM_LOADER_CHECKSUM_EN
                        csum  <= csum + rx_word;
`endif
                    end
`ifdef ROM_LOADER_CHECKSUM_EN
                    CHK_HI:  hi_byte <= rx_data;
`endif
                    default: ;
                endcase
            end
        end
    end

    // NOTE: the memory array has no reset; the program survives a reset by design.
    always_ff @(posedge clk) begin
        if (rom_we) rom[waddr] <= rx_word;
    end

    assign instruction = rom[pc];

endmodule
